adau_cfg_sequencer: RTL

- Sequences the ADAU1761 codec configuration. Walks an external register-write table and issues each entry to the byte-level I2C master through a valid/ready command port.
- Inserts table-directed millisecond delays, used for PLL lock and power-up.
- After configuration completes, arbitrates runtime host register writes (volume, mux, switch-driven changes) onto the same I2C master.
- Sits between the table ROM, the runtime control logic and the I2C engine in the codec wrapper.

---
 rtl/adau_cfg_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/adau_cfg_sequencer.sv
// ADAU1761 configuration sequencer: walks the register table, then serves host writes.
// Optional CFG_RETRY_EN: retry NACKed writes up to MAX_RETRY times before failing.
module adau_cfg_sequencer #(
  parameter int IDX_W      = 6,
  parameter int CLK_PER_MS = 48000,
  parameter int PWRUP_MS   = 10,
  parameter int MAX_RETRY  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [15:0]      tbl_addr,
  input  logic [7:0]       tbl_data,
  input  logic             tbl_last,
  output logic             i2c_valid,
  input  logic             i2c_ready,
  output logic [15:0]      i2c_addr,
  output logic [7:0]       i2c_data,
  input  logic             i2c_done,
  input  logic             i2c_nack,
  input  logic             host_req,
  input  logic [15:0]      host_addr,
  input  logic [7:0]       host_data,
  output logic             host_ack,
  output logic             busy,
  output logic             cfg_done,
  output logic             error
);

  typedef enum logic [3:0] {
    IDLE, PWRUP, FETCH, ISSUE, WAIT,
    DELAY, READY, H_ISSUE, H_WAIT, ERR
  } state_t;

  localparam logic [31:0] PWR_CYC = 32'(PWRUP_MS * CLK_PER_MS);

`ifdef CFG_RETRY_EN
  localparam logic RTY_EN = 1'b1;
`else
  localparam logic RTY_EN = 1'b0;
`endif

  state_t      state, state_n;
  logic [31:0] cnt;
  logic [31:0] dly_cyc;
  logic [7:0]  rty;
  logic        last_q, pend, err_q, ack_q;
  logic        go_pwr, adv, ld_dly, lat_tbl, lat_host;
  logic        rty_inc, rty_ok, set_err, ack_n, pend_set, inc_idx;

  assign dly_cyc   = 32'(tbl_data) * 32'(CLK_PER_MS);
  assign rty_ok    = RTY_EN && (rty < 8'(MAX_RETRY));
  assign i2c_valid = (state == ISSUE) || (state == H_ISSUE);
  assign busy      = (state == PWRUP) || (state == FETCH) ||
                     (state == ISSUE) || (state == WAIT) ||
                     (state == DELAY);
  assign cfg_done  = (state == READY) || (state == H_ISSUE) ||
                     (state == H_WAIT);
  assign error     = err_q;
  assign host_ack  = ack_q;

  // Next state and datapath strobes; a start during a live bus transfer is deferred.
  always_comb begin
    state_n  = state;
    go_pwr   = 1'b0;
    adv      = 1'b0;
    ld_dly   = 1'b0;
    lat_tbl  = 1'b0;
    lat_host = 1'b0;
    rty_inc  = 1'b0;
    set_err  = 1'b0;
    ack_n    = 1'b0;
    pend_set = 1'b0;
    inc_idx  = 1'b0;
    unique case (state)
      IDLE: go_pwr = start;
      PWRUP: begin
        if (start) go_pwr = 1'b1;
        else if (cnt <= 32'd1) state_n = FETCH;
      end
      FETCH: begin
        if (start) begin
          go_pwr = 1'b1;
        end else if (tbl_addr == 16'hFFFF) begin
          state_n = DELAY;
          ld_dly  = 1'b1;
        end else begin
          state_n = ISSUE;
          lat_tbl = 1'b1;
        end
      end
      ISSUE: begin
        if (i2c_ready) begin
          state_n  = WAIT;
          pend_set = start;
        end else if (start) begin
          go_pwr = 1'b1;
        end
      end
      WAIT: begin
        pend_set = start;
        if (i2c_done) begin
          if (pend || start) begin
            go_pwr = 1'b1;
          end else if (!i2c_nack) begin
            adv = 1'b1;
          end else if (rty_ok) begin
            state_n = ISSUE;
            rty_inc = 1'b1;
          end else begin
            state_n = ERR;
            set_err = 1'b1;
          end
        end
      end
      DELAY: begin
        if (start) go_pwr = 1'b1;
        else if (cnt <= 32'd1) adv = 1'b1;
      end
      READY: begin
        if (start) begin
          go_pwr = 1'b1;
        end else if (host_req) begin
          state_n  = H_ISSUE;
          lat_host = 1'b1;
        end
      end
      H_ISSUE: begin
        if (i2c_ready) begin
          state_n  = H_WAIT;
          pend_set = start;
        end else if (start) begin
          go_pwr = 1'b1;
        end
      end
      H_WAIT: begin
        pend_set = start;
        if (i2c_done) begin
          if (pend || start) begin
            go_pwr = 1'b1;
          end else if (i2c_nack && rty_ok) begin
            state_n = H_ISSUE;
            rty_inc = 1'b1;
          end else begin
            state_n = READY;
            ack_n   = 1'b1;
            set_err = i2c_nack;
          end
        end
      end
      ERR: go_pwr = start;
      default: state_n = IDLE;
    endcase
    if (adv) begin
      if (last_q) begin
        state_n = READY;
      end else if (&tbl_idx) begin
        state_n = ERR;
        set_err = 1'b1;
      end else begin
        state_n = FETCH;
        inc_idx = 1'b1;
      end
    end
    if (go_pwr) state_n = PWRUP;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Counters, command latches, retry count and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rty      <= '0;
      last_q   <= 1'b0;
      pend     <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      tbl_idx  <= '0;
      i2c_addr <= '0;
      i2c_data <= '0;
    end else begin
      ack_q <= ack_n;
      if (go_pwr) begin
        cnt     <= PWR_CYC;
        rty     <= '0;
        pend    <= 1'b0;
        err_q   <= 1'b0;
        tbl_idx <= '0;
      end else begin
        if (state == PWRUP || state == DELAY) cnt <= cnt - 32'd1;
        if (ld_dly) cnt <= dly_cyc;
        if (state == FETCH) last_q <= tbl_last;
        if (lat_tbl) begin
          i2c_addr <= tbl_addr;
          i2c_data <= tbl_data;
          rty      <= '0;
        end
        if (lat_host) begin
          i2c_addr <= host_addr;
          i2c_data <= host_data;
          rty      <= '0;
        end
        if (rty_inc)  rty     <= rty + 8'd1;
        if (inc_idx)  tbl_idx <= tbl_idx + IDX_W'(1);
        if (set_err)  err_q   <= 1'b1;
        if (pend_set) pend    <= 1'b1;
      end
    end
  end

endmodule
